// File: rtl/sha2_pkg.sv
// Shared SHA-2 message-schedule definitions: legal word/round pairs, sigma
// rotation constants, the scheduler state enum and the small sigma helpers.
package sha2_pkg;

  localparam int SHA256_WORD_W = 32;
  localparam int SHA256_ROUNDS = 64;
  localparam int SHA512_WORD_W = 64;
  localparam int SHA512_ROUNDS = 80;

  localparam int S0_ROT_A_32 = 7;
  localparam int S0_ROT_B_32 = 18;
  localparam int S0_SHR_32   = 3;
  localparam int S1_ROT_A_32 = 17;
  localparam int S1_ROT_B_32 = 19;
  localparam int S1_SHR_32   = 10;

  localparam int S0_ROT_A_64 = 1;
  localparam int S0_ROT_B_64 = 8;
  localparam int S0_SHR_64   = 7;
  localparam int S1_ROT_A_64 = 19;
  localparam int S1_ROT_B_64 = 61;
  localparam int S1_SHR_64   = 6;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } wsched_state_e;

  function automatic bit sha2_cfg_legal(input int word_w, input int rounds);
    return ((word_w == SHA256_WORD_W) && (rounds == SHA256_ROUNDS)) ||
           ((word_w == SHA512_WORD_W) && (rounds == SHA512_ROUNDS));
  endfunction

  // 32-bit words live in the low half of a 64-bit carrier; the high half is zero.
  function automatic logic [63:0] sha2_rotr(input int word_w, input logic [63:0] x,
                                            input int n);
    logic [31:0] lo;
    lo = x[31:0];
    if (word_w == SHA256_WORD_W) begin
      return {32'h0, (lo >> n) | (lo << (32 - n))};
    end
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [63:0] sha2_s0(input int word_w, input logic [63:0] x);
    logic [63:0] xl;
    xl = {32'h0, x[31:0]};
    if (word_w == SHA256_WORD_W) begin
      return sha2_rotr(word_w, xl, S0_ROT_A_32) ^ sha2_rotr(word_w, xl, S0_ROT_B_32) ^
             (xl >> S0_SHR_32);
    end
    return sha2_rotr(word_w, x, S0_ROT_A_64) ^ sha2_rotr(word_w, x, S0_ROT_B_64) ^
           (x >> S0_SHR_64);
  endfunction

  function automatic logic [63:0] sha2_s1(input int word_w, input logic [63:0] x);
    logic [63:0] xl;
    xl = {32'h0, x[31:0]};
    if (word_w == SHA256_WORD_W) begin
      return sha2_rotr(word_w, xl, S1_ROT_A_32) ^ sha2_rotr(word_w, xl, S1_ROT_B_32) ^
             (xl >> S1_SHR_32);
    end
    return sha2_rotr(word_w, x, S1_ROT_A_64) ^ sha2_rotr(word_w, x, S1_ROT_B_64) ^
           (x >> S1_SHR_64);
  endfunction

endpackage

// File: rtl/sha2_wsched_sigma.sv
// Combinational next-word generator: Wn = s1(win14) + win9 + s0(win1) + win0,
// wrapping modulo 2^WORD_W.
module sha2_wsched_sigma
  import sha2_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic [WORD_W-1:0] win0,
  input  logic [WORD_W-1:0] win1,
  input  logic [WORD_W-1:0] win9,
  input  logic [WORD_W-1:0] win14,
  output logic [WORD_W-1:0] wn
);

  always_comb begin
    wn = WORD_W'(sha2_s1(WORD_W, 64'(win14))) + win9 +
         WORD_W'(sha2_s0(WORD_W, 64'(win1))) + win0;
  end

endmodule

// File: rtl/sha_wsched_param.sv
// SHA-2 message-schedule streamer: takes one 16-word block and emits
// W[0..ROUNDS-1] over a valid/ready interface, with abort and a done pulse.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | blk_ready=1; waiting for a block, window holds stale data
//   ST_RUN  | w_valid=1; win[0] is W[t], shifts on each accepted beat
module sha_wsched_param
  import sha2_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int ROUNDS = (WORD_W == 64) ? 80 : 64,
  parameter int IDX_W  = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 blk_valid,
  output logic                 blk_ready,
  input  logic [16*WORD_W-1:0] block,
  input  logic                 abort,
  output logic                 w_valid,
  input  logic                 w_ready,
  output logic [WORD_W-1:0]    w_data,
  output logic [IDX_W-1:0]     w_idx,
  output logic                 last,
  output logic                 done
);

  if (!sha2_cfg_legal(WORD_W, ROUNDS)) begin : g_bad_cfg
    $error("sha_wsched_param: WORD_W/ROUNDS must be 32/64 or 64/80");
  end
  if ((2 ** IDX_W) < ROUNDS) begin : g_bad_idx
    $error("sha_wsched_param: IDX_W too narrow for ROUNDS");
  end

  localparam logic [IDX_W-1:0] LAST_T = IDX_W'(ROUNDS - 1);

  wsched_state_e      state_q, state_d;
  logic [IDX_W-1:0]   t_q, t_d;
  logic               done_q, done_d;
  logic [WORD_W-1:0]  win_q [16];
  logic [WORD_W-1:0]  win_d [16];
  logic [WORD_W-1:0]  wn;

  sha2_wsched_sigma #(.WORD_W(WORD_W)) u_sigma (
    .win0  (win_q[0]),
    .win1  (win_q[1]),
    .win9  (win_q[9]),
    .win14 (win_q[14]),
    .wn    (wn)
  );

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    done_d  = 1'b0;
    win_d   = win_q;
    // abort outranks both block acceptance and beat handshakes
    if (abort) begin
      state_d = ST_IDLE;
      t_d     = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (blk_valid) begin
            for (int i = 0; i < 16; i++) begin
              win_d[i] = block[(15-i)*WORD_W +: WORD_W];
            end
            t_d     = '0;
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_ready) begin
            for (int i = 0; i < 15; i++) begin
              win_d[i] = win_q[i+1];
            end
            win_d[15] = wn;
            if (t_q == LAST_T) begin
              state_d = ST_IDLE;
              t_d     = '0;
              done_d  = 1'b1;
            end else begin
              t_d = t_q + IDX_W'(1);
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          t_d     = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      t_q     <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      done_q  <= done_d;
      win_q   <= win_d;
    end
  end

  assign blk_ready = (state_q == ST_IDLE);
  assign w_valid   = (state_q == ST_RUN);
  assign w_data    = win_q[0];
  assign w_idx     = t_q;
  assign last      = w_valid && (t_q == LAST_T);
  assign done      = done_q;

endmodule
